// File: rtl/proc_pkg.sv
// Shared definitions for the pipeline's stage-4 memory interface:
// responder FSM encoding, control-FSM opcodes and default widths.
package proc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } mem_state_t;

    localparam logic [3:0] LOAD  = 4'b0000;
    localparam logic [3:0] STORE = 4'b0010;

    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int WAIT_CNT_W      = 4;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage with a synchronous write port and a registered read port.
// The array itself is never reset; only the read register is.
module mem_array
    import proc_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for stage-4 loads/stores: latches one request, inserts
// WAIT_CYCLES wait states, then performs the access and pulses Ready for one cycle.
module data_mem_responder
    import proc_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    input  logic              Flush,
    input  logic              ErrClr,
    output logic [DATA_W-1:0] RData,
    output logic              Ready,
    output logic              Stall,
    output logic              Busy,
    output logic              ReqErr
);

    mem_state_t              state, state_nxt;
    logic [WAIT_CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic [3:0]              op_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic                    req_valid;
    logic                    req_illegal;
    logic                    accept;
    logic                    rd_en;
    logic                    wr_en;
    logic [ADDR_W-1:0]       rd_addr;

    assign req_illegal = MemRead & MemWrite;
    assign req_valid   = (MemRead ^ MemWrite) & ~Flush;
    assign accept      = (state == IDLE) & req_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q    <= LOAD;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            op_q    <= MemRead ? LOAD : STORE;
            addr_q  <= Addr;
            wdata_q <= WData;
        end
    end

    // A new illegal request wins over a clear arriving in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ReqErr <= 1'b0;
        end else if ((state == IDLE) && req_illegal) begin
            ReqErr <= 1'b1;
        end else if (ErrClr) begin
            ReqErr <= 1'b0;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        Ready        = 1'b0;
        Stall        = 1'b0;
        Busy         = 1'b1;
        case (state)
            IDLE: begin
                Busy = 1'b0;
                if (req_valid) begin
                    Stall = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = WAIT_CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_nxt = ACCESS;
                    end
                end
            end
            WAIT: begin
                Stall = 1'b1;
                if (Flush) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == '0) begin
                    state_nxt = ACCESS;
                end else begin
                    wait_cnt_nxt = wait_cnt - 1'b1;
                end
            end
            ACCESS: begin
                Ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // With no wait states the read happens on the accepting edge, before addr_q is loaded.
    assign rd_addr = (state == IDLE) ? Addr : addr_q;
    assign rd_en   = (state_nxt == ACCESS) &&
                     ((state == IDLE) ? MemRead : (op_q == LOAD));
    assign wr_en   = (state == ACCESS) && (op_q == STORE);

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (addr_q),
        .wr_data (wdata_q),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (RData)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: two instances (2 and 0 wait states)
// driven by directed and random transactions against a per-instance memory model.
module tb_data_mem_responder;

    localparam int M_NORMAL  = 0;
    localparam int M_DISTURB = 1;
    localparam int M_FLUSH   = 2;
    localparam int M_RESET   = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic [1:0]       mem_read, mem_write, flush, err_clr;
    logic [1:0][7:0]  addr, wdata, rdata;
    logic [1:0]       ready, stall, busy, req_err;

    typedef struct {
        int         idx;
        int         cycle;
        logic [7:0] rdata;
    } sb_entry_t;

    sb_entry_t  sb_q[$];
    logic [7:0] ref_mem [2][256];
    logic [7:0] ref_rdata [2];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        data_mem_responder #(
            .ADDR_W      (8),
            .DATA_W      (8),
            .WAIT_CYCLES (g == 0 ? 2 : 0)
        ) dut (
            .clock    (clock),
            .reset    (reset),
            .MemRead  (mem_read[g]),
            .MemWrite (mem_write[g]),
            .Addr     (addr[g]),
            .WData    (wdata[g]),
            .Flush    (flush[g]),
            .ErrClr   (err_clr[g]),
            .RData    (rdata[g]),
            .Ready    (ready[g]),
            .Stall    (stall[g]),
            .Busy     (busy[g]),
            .ReqErr   (req_err[g])
        );
    end

    function automatic int wc(input int idx);
        return (idx == 0) ? 2 : 0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int idx, input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        mem_read[idx]  = rd;
        mem_write[idx] = wr;
        addr[idx]      = a;
        wdata[idx]     = d;
    endtask

    // Every Ready must match the oldest outstanding transaction in cycle and data.
    sb_entry_t mon_e;
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (ready[i] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_ready", {31'd0, ready[i]}, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    checkOutput("ready_instance", i, mon_e.idx);
                    checkOutput("ready_cycle", cyc, mon_e.cycle);
                    checkOutput("rdata", {24'd0, rdata[i]}, {24'd0, mon_e.rdata});
                end
            end
        end
    end

    task automatic applyStimulus(input int idx, input bit is_load, input logic [7:0] a,
                                 input logic [7:0] d, input int mode);
        int        w;
        sb_entry_t e;
        w = wc(idx);
        drive(idx, is_load, !is_load, a, d);
        if (mode == M_NORMAL || mode == M_DISTURB) begin
            e.idx   = idx;
            e.cycle = cyc + w + 1;
            e.rdata = is_load ? ref_mem[idx][a] : ref_rdata[idx];
            sb_q.push_back(e);
            if (is_load) ref_rdata[idx] = ref_mem[idx][a];
            else         ref_mem[idx][a] = d;
        end
        @(negedge clock);
        checkOutput("stall_on_request", {31'd0, stall[idx]}, 32'd1);
        checkOutput("busy_on_request", {31'd0, busy[idx]}, 32'd0);
        step();
        if (mode == M_DISTURB) drive(idx, 1'b1, 1'b0, a ^ 8'h01, d ^ 8'hFF);
        else                   drive(idx, 1'b0, 1'b0, 8'h00, 8'h00);
        if (mode == M_FLUSH) begin
            flush[idx] = 1'b1;
            @(negedge clock);
            checkOutput("stall_wait_flush", {31'd0, stall[idx]}, 32'd1);
            step();
            flush[idx] = 1'b0;
            @(negedge clock);
            checkOutput("busy_after_flush", {31'd0, busy[idx]}, 32'd0);
            checkOutput("stall_after_flush", {31'd0, stall[idx]}, 32'd0);
            repeat (w + 1) step();
            return;
        end
        if (mode == M_RESET) begin
            #3 reset = 1'b0;
            #1;
            checkOutput("ready_in_reset", {31'd0, ready[idx]}, 32'd0);
            checkOutput("stall_in_reset", {31'd0, stall[idx]}, 32'd0);
            checkOutput("busy_in_reset", {31'd0, busy[idx]}, 32'd0);
            checkOutput("rdata_in_reset", {24'd0, rdata[idx]}, 32'd0);
            ref_rdata[0] = 8'h00;
            ref_rdata[1] = 8'h00;
            #2 reset = 1'b1;
            step();
            return;
        end
        for (int k = 1; k <= w; k++) begin
            @(negedge clock);
            checkOutput("stall_wait", {31'd0, stall[idx]}, 32'd1);
            checkOutput("busy_wait", {31'd0, busy[idx]}, 32'd1);
            step();
        end
        if (mode == M_DISTURB) begin
            drive(idx, 1'b0, 1'b0, 8'h00, 8'h00);
            flush[idx] = 1'b1;
        end
        @(negedge clock);
        checkOutput("stall_access", {31'd0, stall[idx]}, 32'd0);
        checkOutput("busy_access", {31'd0, busy[idx]}, 32'd1);
        step();
        flush[idx] = 1'b0;
    endtask

    task automatic applyIllegal(input int idx, input bit with_clr);
        drive(idx, 1'b1, 1'b1, 8'h05, 8'hEE);
        err_clr[idx] = with_clr;
        @(negedge clock);
        checkOutput("stall_illegal", {31'd0, stall[idx]}, 32'd0);
        step();
        drive(idx, 1'b0, 1'b0, 8'h00, 8'h00);
        err_clr[idx] = 1'b0;
        @(negedge clock);
        checkOutput("reqerr_set", {31'd0, req_err[idx]}, 32'd1);
        checkOutput("busy_illegal", {31'd0, busy[idx]}, 32'd0);
        step();
    endtask

    task automatic clearErr(input int idx);
        err_clr[idx] = 1'b1;
        step();
        err_clr[idx] = 1'b0;
        @(negedge clock);
        checkOutput("reqerr_cleared", {31'd0, req_err[idx]}, 32'd0);
        step();
    endtask

    initial begin
        reset     = 1'b0;
        mem_read  = '0;
        mem_write = '0;
        flush     = '0;
        err_clr   = '0;
        addr      = '0;
        wdata     = '0;
        ref_rdata = '{8'h00, 8'h00};
        step();
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_rdata", {24'd0, rdata[i]}, 32'd0);
            checkOutput("reset_ready", {31'd0, ready[i]}, 32'd0);
            checkOutput("reset_stall", {31'd0, stall[i]}, 32'd0);
            checkOutput("reset_busy", {31'd0, busy[i]}, 32'd0);
            checkOutput("reset_reqerr", {31'd0, req_err[i]}, 32'd0);
        end
        reset = 1'b1;
        step();

        $display("[TB] basic store/load on both instances");
        applyStimulus(0, 1'b0, 8'h10, 8'hA5, M_NORMAL);
        applyStimulus(0, 1'b1, 8'h10, 8'h00, M_NORMAL);
        applyStimulus(1, 1'b0, 8'h20, 8'h3C, M_NORMAL);
        applyStimulus(1, 1'b1, 8'h20, 8'h00, M_NORMAL);

        for (int i = 0; i < 2; i++) begin
            applyStimulus(i, 1'b0, 8'h05, 8'h5A, M_NORMAL);
            applyStimulus(i, 1'b0, 8'h30, 8'h11, M_NORMAL);
            applyStimulus(i, 1'b0, 8'h40, 8'hC3, M_NORMAL);
            applyStimulus(i, 1'b0, 8'h60, 8'h00, M_NORMAL);
            applyStimulus(i, 1'b0, 8'h61, 8'h22, M_NORMAL);
            for (int j = 0; j < 16; j++) begin
                applyStimulus(i, 1'b0, 8'h80 + 8'(j), 8'($urandom), M_NORMAL);
            end
        end

        $display("[TB] illegal requests and error clearing");
        applyIllegal(0, 1'b0);
        clearErr(0);
        applyIllegal(0, 1'b1);
        clearErr(0);
        applyStimulus(0, 1'b1, 8'h05, 8'h00, M_NORMAL);

        $display("[TB] flush, reset and disturbance during wait");
        applyStimulus(0, 1'b0, 8'h30, 8'hFF, M_FLUSH);
        applyStimulus(0, 1'b1, 8'h30, 8'h00, M_NORMAL);
        applyStimulus(0, 1'b0, 8'h40, 8'h9E, M_RESET);
        applyStimulus(0, 1'b1, 8'h40, 8'h00, M_NORMAL);
        applyStimulus(1, 1'b1, 8'h05, 8'h00, M_NORMAL);
        applyStimulus(0, 1'b0, 8'h60, 8'h77, M_DISTURB);
        applyStimulus(0, 1'b1, 8'h60, 8'h00, M_NORMAL);
        applyStimulus(0, 1'b1, 8'h61, 8'h00, M_NORMAL);

        $display("[TB] random traffic");
        for (int n = 0; n < 80; n++) begin
            applyStimulus(n % 2, 1'($urandom_range(0, 1)), 8'h80 + 8'($urandom_range(0, 15)),
                          8'($urandom), M_NORMAL);
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (4) step();
        checkOutput("scoreboard_drain", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the 5-stage pipeline; it is the memory-side end of the stage-4 MemRead/MemWrite request interface driven by the pipeline control FSM.
- Latches one load/store request, inserts a programmable number of wait states, then performs the access and pulses Ready.
- Holds Stall high while an access is in flight so the control FSM freezes the pipeline.
- Supports flush of a pending access on branch failure and flags illegal read+write requests.

Parameters:
ADDR_W, 8, address width; memory depth is 2**ADDR_W words
DATA_W, 8, data word width
WAIT_CYCLES, 2, wait states inserted before access, legal range 0..15

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
MemRead  in  1  load request from stage 4
MemWrite  in  1  store request from stage 4
Addr  in  ADDR_W  request address
WData  in  DATA_W  store data
Flush  in  1  abort the pending access (branch fail or stop)
ErrClr  in  1  clears ReqErr
RData  out  DATA_W  registered load data
Ready  out  1  one-cycle pulse: access complete
Stall  out  1  pipeline hold request
Busy  out  1  state != IDLE
ReqErr  out  1  sticky illegal-request flag

Behaviour:
- Reset (reset==0, async): state=IDLE, wait counter=0, RData=0, Ready=0, ReqErr=0, latched op/addr/data=0. Memory contents are not cleared. A pending store is discarded.
- States: IDLE, WAIT, ACCESS.
- IDLE:
  - Valid request is exactly one of MemRead/MemWrite high, with Flush=0. On the clock edge, latch op, Addr and WData.
  - If WAIT_CYCLES>0: counter=WAIT_CYCLES-1, go to WAIT. Otherwise go directly to ACCESS.
  - MemRead&MemWrite both high: set ReqErr, no access, stay IDLE, Stall=0.
- WAIT:
  - Counter decrements each cycle. When counter==0, go to ACCESS on the next edge.
  - Request inputs are ignored; the latched values are used.
- Load data timing: RData<=mem[addr_q] on the edge that enters ACCESS, for loads only. RData holds its value otherwise.
- ACCESS:
  - Lasts exactly one cycle with Ready=1.
  - A store commits mem[addr_q]<=wdata_q on the edge that leaves ACCESS.
  - Always returns to IDLE. A new request is not accepted in this cycle.
- Stall (combinational) = (IDLE & valid request) | WAIT. Stall=0 during ACCESS, so the pipeline advances with Ready.
- Latency: request first seen in cycle t gives Ready in cycle t+WAIT_CYCLES+1. A store is visible to a load issued from cycle t+WAIT_CYCLES+2.
- Flush:
  - In IDLE: suppresses acceptance.
  - In WAIT: returns to IDLE next edge, no store, RData unchanged, Ready never pulses.
  - In ACCESS: ignored; the access completes.
- ReqErr: set has priority over ErrClr in the same cycle. ErrClr alone clears it next edge.
- Busy=1 in WAIT and ACCESS.
- Back-to-back requests: the earliest next acceptance is the IDLE cycle after ACCESS. The requester must have dropped or changed its request after seeing Ready.

Decomposition:
- Shared package proc_pkg holds:
  - state encoding (IDLE=2'd0, WAIT=2'd1, ACCESS=2'd2)
  - the opcode constants LOAD=4'b0000 and STORE=4'b0010 used by the control FSM
  - the default widths
- One sub-module, mem_array: 2**ADDR_W x DATA_W storage with synchronous write port and registered read port, instantiated once.

Test Plan:
- Reset, then store WData=8'hA5 to Addr=8'h10 with WAIT_CYCLES=2 -> Stall high for 3 cycles, Ready pulses in cycle 3; a load of 8'h10 then returns RData=8'hA5 with Ready 3 cycles after its request.
- WAIT_CYCLES=0: load from Addr=8'h20 pre-written with 8'h3C -> Ready and RData=8'h3C in the cycle after the request; Stall high for exactly 1 cycle.
- MemRead=MemWrite=1 at Addr=8'h05 -> ReqErr=1 next cycle, Stall=0, Busy=0, memory unchanged. ErrClr=1 -> ReqErr=0; simultaneous illegal request plus ErrClr -> ReqErr stays 1.
- Store 8'hFF to 8'h30 (old value 8'h11), Flush=1 during the first WAIT cycle -> IDLE next edge, no Ready pulse, a later load returns 8'h11.
- Drive reset low mid-WAIT of a store to 8'h40 -> immediately state=IDLE, Ready=0, Stall=0, RData=0; mem[8'h40] unchanged.
- Change Addr and WData during WAIT -> access uses the values latched at acceptance; Flush asserted during ACCESS -> store still commits.
